// File: rtl/fp32_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : fp32_multiplier
// Purpose  : IEEE-754 binary32 multiplier, data_out = in_a * in_b, rounded
//            to nearest, ties to even. Fully pipelined: one operand pair
//            accepted per clock, result strobed exactly three edges after
//            the edge that sampled the pair.
// Ports    : clk           - clock, all state updates on posedge
//            reset_n       - asynchronous active-low reset
//            input_valid   - in_a/in_b valid this cycle
//            in_a, in_b    - binary32 operands
//            data_out      - binary32 product (registered, held when idle)
//            output_valid  - one-cycle strobe, data_out valid this cycle
// Config   : FP_MUL_SUBNORMAL_EN - when defined, subnormal operands and
//            results are handled exactly; otherwise subnormals flush to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_multiplier (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        input_valid,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] data_out,
    output logic        output_valid
);

    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Operand capture: the edge that samples input_valid=1 registers the
    // pair here; the three arithmetic stages follow.
    // ------------------------------------------------------------------
    logic        cap_valid_q;
    logic [31:0] cap_a_q;
    logic [31:0] cap_b_q;

    // ------------------------------------------------------------------
    // S1: unpack, classify, exponent sum, significand product
    // ------------------------------------------------------------------
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [23:0] ma, mb;
    logic [7:0]  ea_eff, eb_eff;
    logic        s1_nan_d, s1_inf_d, s1_zero_d, s1_sign_d;
    logic signed [9:0] s1_exp_d;
    logic [47:0] s1_prod_d;

    always_comb begin
        a_nan  = (cap_a_q[30:23] == 8'hFF) && (cap_a_q[22:0] != 23'd0);
        a_inf  = (cap_a_q[30:23] == 8'hFF) && (cap_a_q[22:0] == 23'd0);
        b_nan  = (cap_b_q[30:23] == 8'hFF) && (cap_b_q[22:0] != 23'd0);
        b_inf  = (cap_b_q[30:23] == 8'hFF) && (cap_b_q[22:0] == 23'd0);
`ifdef FP_MUL_SUBNORMAL_EN
        // Subnormal: implicit bit 0, effective exponent 1.
        a_zero = (cap_a_q[30:0] == 31'd0);
        b_zero = (cap_b_q[30:0] == 31'd0);
        ma     = {(cap_a_q[30:23] != 8'd0), cap_a_q[22:0]};
        mb     = {(cap_b_q[30:23] != 8'd0), cap_b_q[22:0]};
        ea_eff = (cap_a_q[30:23] == 8'd0) ? 8'd1 : cap_a_q[30:23];
        eb_eff = (cap_b_q[30:23] == 8'd0) ? 8'd1 : cap_b_q[30:23];
`else
        // Flush-to-zero: any zero exponent field is treated as signed zero.
        a_zero = (cap_a_q[30:23] == 8'd0);
        b_zero = (cap_b_q[30:23] == 8'd0);
        ma     = {1'b1, cap_a_q[22:0]};
        mb     = {1'b1, cap_b_q[22:0]};
        ea_eff = cap_a_q[30:23];
        eb_eff = cap_b_q[30:23];
`endif
        s1_nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s1_inf_d  = a_inf | b_inf;
        s1_zero_d = a_zero | b_zero;
        s1_sign_d = cap_a_q[31] ^ cap_b_q[31];
        s1_exp_d  = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - 10'sd127;
        s1_prod_d = {24'd0, ma} * {24'd0, mb};
    end

    logic              s1_valid_q;
    logic              s1_nan_q, s1_inf_q, s1_zero_q, s1_sign_q;
    logic signed [9:0] s1_exp_q;
    logic [47:0]       s1_prod_q;

    // ------------------------------------------------------------------
    // S2: normalise so the leading one sits at bit 47, derive G/R/S
    // ------------------------------------------------------------------
    logic [47:0]       norm;
    logic              lost;
    logic signed [9:0] exp_n;
    logic [23:0]       s2_mant_d;
    logic              s2_g_d, s2_r_d, s2_s_d;
`ifdef FP_MUL_SUBNORMAL_EN
    logic [5:0]        lzc;
    logic signed [9:0] sh;
    logic [5:0]        shamt;
`endif

    always_comb begin
        norm  = s1_prod_q;
        lost  = 1'b0;
        exp_n = s1_exp_q;
`ifdef FP_MUL_SUBNORMAL_EN
        lzc   = 6'd0;
        sh    = 10'sd0;
        shamt = 6'd0;
        // Highest set bit wins: the loop runs upward, last hit is the MSB.
        for (int i = 0; i < 48; i++) begin
            if (s1_prod_q[i]) lzc = 6'(47 - i);
        end
        norm  = s1_prod_q << lzc;
        exp_n = s1_exp_q + 10'sd1 - $signed({4'b0000, lzc});
        if (exp_n <= 10'sd0) begin
            // Below min normal: denormalise to exponent field 0 (scale of
            // exponent 1). Anything shifted out folds into sticky.
            sh    = 10'sd1 - exp_n;
            shamt = (sh > 10'sd48) ? 6'd48 : sh[5:0];
            lost  = |(norm & ~({48{1'b1}} << shamt));
            norm  = norm >> shamt;
            exp_n = 10'sd0;
        end
`else
        // Normal x normal lies in [1,4): only one possible position shift.
        if (s1_prod_q[47]) begin
            exp_n = s1_exp_q + 10'sd1;
        end else begin
            norm = s1_prod_q << 1;
        end
`endif
        s2_mant_d = norm[47:24];
        s2_g_d    = norm[23];
        s2_r_d    = norm[22];
        s2_s_d    = (|norm[21:0]) | lost;
    end

    logic              s2_valid_q;
    logic              s2_nan_q, s2_inf_q, s2_zero_q, s2_sign_q;
    logic signed [9:0] s2_exp_q;
    logic [23:0]       s2_mant_q;
    logic              s2_g_q, s2_r_q, s2_s_q;

    // ------------------------------------------------------------------
    // S3: round to nearest even, special-case priority, pack
    // ------------------------------------------------------------------
    logic              inc;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [22:0]       frac;
    logic [31:0]       data_out_d;

    always_comb begin
        inc    = s2_g_q & (s2_r_q | s2_s_q | s2_mant_q[0]);
        mant_r = {1'b0, s2_mant_q} + {24'd0, inc};
        exp_r  = s2_exp_q + $signed({9'd0, mant_r[24]});
`ifdef FP_MUL_SUBNORMAL_EN
        // Subnormal that rounds up into the implicit bit becomes 2^-126.
        if ((s2_exp_q == 10'sd0) && mant_r[23]) exp_r = 10'sd1;
`endif
        frac = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

        if (s2_nan_q) begin
            data_out_d = c_QNAN;
        end else if (s2_inf_q) begin
            data_out_d = {s2_sign_q, 8'hFF, 23'd0};
        end else if (s2_zero_q) begin
            data_out_d = {s2_sign_q, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            data_out_d = {s2_sign_q, 8'hFF, 23'd0};
`ifndef FP_MUL_SUBNORMAL_EN
        end else if (exp_r <= 10'sd0) begin
            data_out_d = {s2_sign_q, 31'd0};
`endif
        end else begin
            data_out_d = {s2_sign_q, exp_r[7:0], frac};
        end
    end

    logic [31:0] data_out_q;
    logic        output_valid_q;

    // ------------------------------------------------------------------
    // Registers. Valid bits and outputs are reset; datapath is not, since
    // its contents are never observed without a matching valid bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_valid_q    <= 1'b0;
            s1_valid_q     <= 1'b0;
            s2_valid_q     <= 1'b0;
            output_valid_q <= 1'b0;
            data_out_q     <= 32'd0;
        end else begin
            cap_valid_q    <= input_valid;
            s1_valid_q     <= cap_valid_q;
            s2_valid_q     <= s1_valid_q;
            output_valid_q <= s2_valid_q;
            if (s2_valid_q) data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (input_valid) begin
            cap_a_q <= in_a;
            cap_b_q <= in_b;
        end
        s1_nan_q  <= s1_nan_d;
        s1_inf_q  <= s1_inf_d;
        s1_zero_q <= s1_zero_d;
        s1_sign_q <= s1_sign_d;
        s1_exp_q  <= s1_exp_d;
        s1_prod_q <= s1_prod_d;
        s2_nan_q  <= s1_nan_q;
        s2_inf_q  <= s1_inf_q;
        s2_zero_q <= s1_zero_q;
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= exp_n;
        s2_mant_q <= s2_mant_d;
        s2_g_q    <= s2_g_d;
        s2_r_q    <= s2_r_d;
        s2_s_q    <= s2_s_d;
    end

    assign data_out     = data_out_q;
    assign output_valid = output_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_multiplier
// Purpose  : Self-checking bench for fp32_multiplier. Directed vectors with
//            hand-computed products, plus sequences for latency, result
//            hold, back-to-back streaming and mid-flight reset.
//            Expected values for subnormal handling follow the
//            FP_MUL_SUBNORMAL_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_multiplier;

    logic        clk;
    logic        reset_n;
    logic        input_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] data_out;
    logic        output_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        string       name;
    } vec_t;

    vec_t vecs[$];

    fp32_multiplier dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .input_valid  (input_valid),
        .in_a         (in_a),
        .in_b         (in_b),
        .data_out     (data_out),
        .output_valid (output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] y, input string name);
        vec_t v;
        v.a = a; v.b = b; v.y = y; v.name = name;
        vecs.push_back(v);
    endtask

    // One pair, then an 8-edge window: latency of first pulse and pulse count.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] y, output int lat, output int pulses);
        lat = 0; pulses = 0; y = 32'd0;
        @(negedge clk);
        in_a = a; in_b = b; input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (output_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    y   = data_out;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] y;
        int          lat;
        int          pulses;
        logic [31:0] got[3];
        int          first_cyc;
        int          n_out;
        logic        contiguous;

        reset_n = 1'b0; input_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;

        add_vec(32'h40000000, 32'h40400000, 32'h40C00000, "2x3");
        add_vec(32'h3FC00000, 32'hC0000000, 32'hC0400000, "1p5xm2");
        add_vec(32'h3F800001, 32'h3F800001, 32'h3F800002, "rne_small");
        add_vec(32'h3F800001, 32'h3FC00000, 32'h3FC00002, "tie_up_odd");
        add_vec(32'h3FC00000, 32'h3F800003, 32'h3FC00004, "tie_down_even");
        add_vec(32'h3FFFFFFE, 32'h3F800001, 32'h40000000, "round_carry");
        add_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, "1x1");
        add_vec(32'h7F000000, 32'h40000000, 32'h7F800000, "ovf");
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "ovf_max");
        add_vec(32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, "ovf_neg");
        add_vec(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_0");
        add_vec(32'h00000000, 32'hFF800000, 32'h7FC00000, "0_x_minf");
        add_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_a");
        add_vec(32'h40000000, 32'hFFC12345, 32'h7FC00000, "nan_b_neg");
        add_vec(32'hFF800000, 32'h40000000, 32'hFF800000, "minf_x_2");
        add_vec(32'h80000000, 32'h3F800000, 32'h80000000, "m0_x_1");
        add_vec(32'h80000000, 32'hBF800000, 32'h00000000, "m0_x_m1");
        add_vec(32'h00800000, 32'h00800000, 32'h00000000, "tiny_x_tiny");
`ifdef FP_MUL_SUBNORMAL_EN
        add_vec(32'h00800000, 32'h3F000000, 32'h00400000, "to_subnormal");
        add_vec(32'h00000001, 32'h7F000000, 32'h34800000, "sub_in");
        add_vec(32'h007FFFFF, 32'h3F800001, 32'h00800000, "sub_round_min");
`else
        add_vec(32'h00800000, 32'h3F000000, 32'h00000000, "to_subnormal");
        add_vec(32'h00000001, 32'h7F000000, 32'h00000000, "sub_in");
        add_vec(32'h007FFFFF, 32'h3F800001, 32'h00000000, "sub_round_min");
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check32("reset_data_out", data_out, 32'd0);
        check_int("reset_valid", int'(output_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Latency, single pulse, and hold while idle
        run_one(32'h40000000, 32'h40400000, y, lat, pulses);
        check_int("latency", lat, 3);
        check_int("single_pulse", pulses, 1);
        check32("lat_result", y, 32'h40C00000);
        check32("hold_idle", data_out, 32'h40C00000);

        // Directed table
        foreach (vecs[i]) begin
            run_one(vecs[i].a, vecs[i].b, y, lat, pulses);
            if (lat == 0) begin
                checks++; errors++;
                $display("FAIL %s: no output_valid within 8 cycles", vecs[i].name);
            end else begin
                check32(vecs[i].name, y, vecs[i].y);
            end
        end

        // Three back-to-back pairs -> three consecutive pulses in order
        @(negedge clk);
        in_a = 32'h3FC00000; in_b = 32'hC0000000; input_valid = 1'b1;
        @(negedge clk);
        in_a = 32'h40000000; in_b = 32'h40400000;
        @(negedge clk);
        in_a = 32'h3F800001; in_b = 32'h3F800001;
        @(negedge clk);
        input_valid = 1'b0;
        n_out = 0; first_cyc = -1; contiguous = 1'b1;
        got[0] = 32'd0; got[1] = 32'd0; got[2] = 32'd0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (output_valid) begin
                if (first_cyc < 0) first_cyc = k;
                if (k != first_cyc + n_out) contiguous = 1'b0;
                if (n_out < 3) got[n_out] = data_out;
                n_out++;
            end
        end
        check_int("b2b_count", n_out, 3);
        check_int("b2b_contiguous", int'(contiguous), 1);
        check_int("b2b_first_edge", first_cyc, 0);
        check32("b2b_0", got[0], 32'hC0400000);
        check32("b2b_1", got[1], 32'h40C00000);
        check32("b2b_2", got[2], 32'h3F800002);

        // Reset mid-flight: outputs clear, in-flight pair never emerges
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h40000000; input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check32("midrst_data_out", data_out, 32'd0);
        check_int("midrst_valid", int'(output_valid), 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (output_valid) pulses++;
        end
        check_int("midrst_no_output", pulses, 0);
        check32("midrst_data_held", data_out, 32'd0);

        // Recovery after reset
        run_one(32'h40000000, 32'h40400000, y, lat, pulses);
        check_int("post_rst_latency", lat, 3);
        check32("post_rst_result", y, 32'h40C00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
